imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 31 +++
 rtl/imem_loader_byte_packer.sv | 57 +++++
 rtl/imem_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
// The state set and field widths are common to the top level and the byte packer.
package imem_loader_pkg;

    localparam int BYTE_W   = 8;
    localparam int WORD_W   = 32;
    localparam int WCOUNT_W = 16;
    localparam int CSUM_W   = 8;
    localparam int ADDR_W   = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    // States in which the loader is part-way through a session and takes bytes.
    function automatic logic session_active(input state_t s);
        return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
    endfunction

    // States from which a start pulse opens a new session.
    function automatic logic start_allowed(input state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler. It holds a 2-bit byte counter and a
// 32-bit assembly register, and flags the cycle in which the 4th byte arrives.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_done,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        cnt_reg;
    logic [1:0]        cnt_next;
    logic [WORD_W-1:0] asm_reg;
    logic [WORD_W-1:0] asm_next;

    // The incoming byte lands in the lane selected by the counter; the other
    // lanes keep their contents. The complete word is visible on asm_next in
    // the same cycle as the final byte so the caller can register it directly.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                asm_next[gi*BYTE_W +: BYTE_W] = asm_reg[gi*BYTE_W +: BYTE_W];
                if (cnt_reg == 2'(gi)) begin
                    asm_next[gi*BYTE_W +: BYTE_W] = byte_data;
                end
            end
        end
    endgenerate

    always_comb begin
        cnt_next = cnt_reg;
        if (byte_en) begin
            cnt_next = cnt_reg + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= 2'd0;
            asm_reg <= '0;
        end else if (clear) begin
            cnt_reg <= 2'd0;
            asm_reg <= '0;
        end else if (byte_en) begin
            cnt_reg <= cnt_next;
            asm_reg <= asm_next;
        end
    end

    assign word_done = byte_en && (cnt_reg == 2'd3);
    assign word      = asm_next;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length header, little-endian word stream,
// XOR checksum trailer. Holds the core in reset until a session completes cleanly.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter logic [63:0] BASE_ADDR  = 64'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One extra bit over the address range so a count of exactly IMEM_WORDS fits.
    localparam int IDX_W = $clog2(IMEM_WORDS + 1);

    state_t              state_reg;
    state_t              state_next;
    logic [IDX_W-1:0]    idx_reg;
    logic [WCOUNT_W-1:0] count_reg;
    logic [CSUM_W-1:0]   csum_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [WORD_W-1:0]   wdata_reg;

    logic                byte_fire;
    logic                start_accept;
    logic                data_fire;
    logic                word_done;
    logic [WORD_W-1:0]   word;
    logic [WCOUNT_W-1:0] count_full;
    logic                count_too_big;
    logic                count_zero;
    logic                last_word;

    assign in_ready     = session_active(state_reg);
    assign byte_fire    = in_valid && in_ready;
    assign start_accept = start && start_allowed(state_reg);
    assign data_fire    = byte_fire && (state_reg == DATA);

    // The high length byte is still on in_data while LEN1 decides where to go.
    assign count_full    = {in_data, count_reg[BYTE_W-1:0]};
    assign count_too_big = 32'(count_full) > 32'(IMEM_WORDS);
    assign count_zero    = (count_full == '0);
    assign last_word     = 32'(idx_reg) == (32'(count_reg) - 32'd1);

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_accept),
        .byte_en   (data_fire),
        .byte_data (in_data),
        .word_done (word_done),
        .word      (word)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = LEN0;
                end
            end
            LEN0: begin
                if (byte_fire) begin
                    state_next = LEN1;
                end
            end
            LEN1: begin
                if (byte_fire) begin
                    if (count_too_big) begin
                        state_next = ERR;
                    end else if (count_zero) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (data_fire && word_done && last_word) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                if (byte_fire) begin
                    state_next = (in_data == csum_reg) ? DONE : ERR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg   <= '0;
            count_reg <= '0;
            csum_reg  <= '0;
        end else if (start_accept) begin
            idx_reg   <= '0;
            count_reg <= '0;
            csum_reg  <= '0;
        end else if (byte_fire) begin
            case (state_reg)
                LEN0: count_reg[BYTE_W-1:0]        <= in_data;
                LEN1: count_reg[WCOUNT_W-1:BYTE_W] <= in_data;
                DATA: begin
                    csum_reg <= csum_reg ^ in_data;
                    if (word_done) begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address and data only move on a write, so they hold between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            we_reg <= data_fire && word_done;
            if (data_fire && word_done) begin
                addr_reg  <= BASE_ADDR + (64'(idx_reg) << 2);
                wdata_reg <= word;
            end
        end
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign busy       = session_active(state_reg);
    assign done       = (state_reg == DONE);
    assign err        = (state_reg == ERR);
    assign core_hold  = (state_reg != DONE);

endmodule
